capture_sequencer: RTL

Sequences one camera capture: flushes the image pipeline, aligns to a whole sensor frame, gates the pipeline for exactly that frame, then waits for compression to drain before raising image ready. Sits between the SPI register block (start_capture, power_save_enable) and the debayer/metering/compression datapath. Also owns sensor clock gating for power save, and a watchdog for a missing sensor or a stuck compressor.

---
 rtl/capture_sequencer_pkg.sv | 16 +
 rtl/capture_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer_pkg.sv
// Shared types and constants for the camera capture sequencer.
package capture_sequencer_pkg;

    localparam int TIMER_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        FLUSH,
        SYNC,
        ARMED,
        CAPTURE,
        DRAIN
    } capture_state_t;

endpackage

// File: rtl/capture_sequencer.sv
// Sequences one camera capture: flush, align to a whole sensor frame, gate the
// pipeline for that frame, wait for compression, then raise image ready.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 4,
    parameter int WAKE_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_capture_in,
    input  logic       power_save_enable_in,
    input  logic       frame_valid_in,
    input  logic       compression_done_in,
    output logic       pipeline_reset_out,
    output logic       pipeline_enable_out,
    output logic       sensor_clock_enable_out,
    output logic       image_ready_out,
    output logic       capture_busy_out,
    output logic       timeout_out,
    output logic [7:0] frame_count_out
);

    localparam logic [TIMER_WIDTH-1:0] FLUSH_LOAD   = TIMER_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] WAKE_LOAD    = TIMER_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);

    capture_state_t         state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   frameValidPrev_q;
    logic                   pipelineReset_q, pipelineReset_d;
    logic                   pipelineEnable_q, pipelineEnable_d;
    logic                   sensorClockEnable_q, sensorClockEnable_d;
    logic                   imageReady_q, imageReady_d;
    logic                   captureBusy_q, captureBusy_d;
    logic                   timeout_q, timeout_d;
    logic [7:0]             frameCount_q, frameCount_d;
    logic                   watchdogActive;
    logic                   timerZero;

    assign watchdogActive = (state_q == SYNC) || (state_q == ARMED) ||
                            (state_q == CAPTURE) || (state_q == DRAIN);
    assign timerZero      = (timer_q == '0);

    always_comb begin
        state_d             = state_q;
        timer_d             = timer_q;
        pipelineReset_d     = 1'b0;
        pipelineEnable_d    = pipelineEnable_q;
        sensorClockEnable_d = sensorClockEnable_q;
        imageReady_d        = imageReady_q;
        timeout_d           = timeout_q;
        frameCount_d        = frameCount_q;

        // One down-counter is shared: WAKE and FLUSH reload it, SYNC onwards it is the watchdog.
        unique case (state_q)
            IDLE: begin
                sensorClockEnable_d = !power_save_enable_in;
                if (start_capture_in) begin
                    imageReady_d        = 1'b0;
                    timeout_d           = 1'b0;
                    sensorClockEnable_d = 1'b1;
                    if (!sensorClockEnable_q) begin
                        state_d = WAKE;
                        timer_d = WAKE_LOAD;
                    end else begin
                        state_d         = FLUSH;
                        timer_d         = FLUSH_LOAD;
                        pipelineReset_d = 1'b1;
                    end
                end
            end
            WAKE: begin
                sensorClockEnable_d = 1'b1;
                if (timerZero) begin
                    state_d         = FLUSH;
                    timer_d         = FLUSH_LOAD;
                    pipelineReset_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            FLUSH: begin
                if (timerZero) begin
                    state_d = SYNC;
                    timer_d = TIMEOUT_LOAD;
                end else begin
                    timer_d         = timer_q - TIMER_ONE;
                    pipelineReset_d = 1'b1;
                end
            end
            SYNC: begin
                if (!frame_valid_in) state_d = ARMED;
            end
            ARMED: begin
                if (frame_valid_in && !frameValidPrev_q) begin
                    pipelineEnable_d = 1'b1;
                    state_d          = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!frame_valid_in && frameValidPrev_q) begin
                    pipelineEnable_d = 1'b0;
                    state_d          = DRAIN;
                end
            end
            DRAIN: begin
                if (compression_done_in) begin
                    imageReady_d = 1'b1;
                    frameCount_d = frameCount_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog expiry overrides whatever the frame logic decided this cycle.
        if (watchdogActive) begin
            if (timerZero) begin
                timeout_d        = 1'b1;
                pipelineEnable_d = 1'b0;
                pipelineReset_d  = 1'b1;
                imageReady_d     = 1'b0;
                frameCount_d     = frameCount_q;
                state_d          = IDLE;
            end else begin
                timer_d = timer_q - TIMER_ONE;
            end
        end

        captureBusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q             <= IDLE;
            timer_q             <= '0;
            frameValidPrev_q    <= 1'b0;
            pipelineReset_q     <= 1'b0;
            pipelineEnable_q    <= 1'b0;
            sensorClockEnable_q <= 1'b1;
            imageReady_q        <= 1'b0;
            captureBusy_q       <= 1'b0;
            timeout_q           <= 1'b0;
            frameCount_q        <= 8'd0;
        end else begin
            state_q             <= state_d;
            timer_q             <= timer_d;
            frameValidPrev_q    <= frame_valid_in;
            pipelineReset_q     <= pipelineReset_d;
            pipelineEnable_q    <= pipelineEnable_d;
            sensorClockEnable_q <= sensorClockEnable_d;
            imageReady_q        <= imageReady_d;
            captureBusy_q       <= captureBusy_d;
            timeout_q           <= timeout_d;
            frameCount_q        <= frameCount_d;
        end
    end

    assign pipeline_reset_out      = pipelineReset_q;
    assign pipeline_enable_out     = pipelineEnable_q;
    assign sensor_clock_enable_out = sensorClockEnable_q;
    assign image_ready_out         = imageReady_q;
    assign capture_busy_out        = captureBusy_q;
    assign timeout_out             = timeout_q;
    assign frame_count_out         = frameCount_q;

endmodule
